sdram_cmd_gen: RTL and testbench
================================

SDRAM_CMD_GEN -- requirements
Module: sdram_cmd_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning): WIDTH_BA 2 bank bits; WIDTH_ROW 13 row/addr bits (>=11); WIDTH_COL 9 column bits (<=10); CL 3 CAS latency (2|3); T_RCD 2; T_RP 2; T_RFC 7; T_MRD 2; T_WR 2 (cycles); T_PWRUP 20000 power-up cycles; REF_INTERVAL 780 cycles between refreshes.
REQ-002 Clocking SHALL be one clock, clk; reset rst is synchronous and active-high.
REQ-003 Ports (name dir width meaning): clk in 1 clock; rst in 1 sync active-high reset.
REQ-004 req_valid in 1 request present; req_ready out 1 request accepted when both high; req_wr in 1 1=write 0=read; req_addr in WIDTH_BA+WIDTH_ROW+WIDTH_COL {bank,row,col}; req_len in 9 burst words 1..256.
REQ-005 init_done out 1 init complete; wr_data_en out 1 write word consumed this cycle; rd_data_valid out 1 read word on DQ this cycle.
REQ-006 sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n out 1 each; sdram_ba out WIDTH_BA; sdram_addr out WIDTH_ROW; all registered.

Function
REQ-007 Command {cke,cs_n,ras_n,cas_n,we_n}: NOP 10111, ACTIVE 10011, READ 10101, WRITE 10100, BSTOP 10110, PRECHARGE 10010, AREF 10001, LMR 10000.
REQ-008 Non-addressed commands SHALL drive ba and addr all ones.
REQ-009 Init FSM SHALL be: INIT_WAIT (NOP, T_PWRUP cycles) -> PRE (A10=1) -> T_RP -> AREF -> T_RFC -> AREF -> T_RFC -> LMR -> T_MRD -> IDLE, then init_done=1 and stays 1.
REQ-010 LMR SHALL drive ba=0, addr[2:0]=111 (full page), A3=0 sequential, A6:4=CL, A8:7=00, A9=0 burst write, A[WIDTH_ROW-1:10]=0.
REQ-011 req_ready SHALL be 1 only in IDLE with init_done=1 and no refresh pending; req_wr/addr/len latched on handshake.
REQ-012 req_len=0 SHALL be treated as 1.
REQ-013 Write: ACTIVE (bank,row) cycle after accept; WRITE (col, A10=0) T_RCD cycles after ACTIVE; wr_data_en high for len cycles starting on the WRITE cycle; BSTOP in the cycle after last word; PRECHARGE (A10=1) T_WR cycles after BSTOP; IDLE T_RP cycles after PRECHARGE.
REQ-014 Read: ACTIVE, READ (col, A10=0) after T_RCD; BSTOP exactly len cycles after READ; rd_data_valid high cycles READ+CL .. READ+CL+len-1; PRECHARGE CL cycles after BSTOP; IDLE T_RP later.
REQ-015 Column addresses SHALL wrap mod 2^WIDTH_COL within the open row; no row/bank crossing.
REQ-016 Refresh timer SHALL count every cycle after init_done, set ref_pending at REF_INTERVAL and restart; pending is a single flag (no accumulation).
REQ-017 ref_pending in IDLE SHALL issue AREF, wait T_RFC, clear pending, return to IDLE; never interrupts a burst.
REQ-018 Refresh expiry coincident with req_valid in IDLE: refresh wins, req_ready=0 that cycle.

Reset
REQ-019 While rst=1: cmd=01111 (cke=0), ba and addr all ones, init_done=0, req_ready=0, wr_data_en=0, rd_data_valid=0, refresh timer and pending cleared.
REQ-020 rst asserted mid-burst or mid-init SHALL abort immediately and restart at INIT_WAIT after release.

Structure
REQ-021 Package sdram_pkg SHALL hold command encodings, FSM state encoding and mode-register field constants.
REQ-022 Refresh interval counter SHALL be sub-module sdram_ref_timer (clk, rst, en, pending, clr).
REQ-023 One shared down-counter SHALL time all T_* waits and burst length.

Verification (T_PWRUP=10, defaults otherwise)
REQ-024 Reset release -> NOP 10 cycles, PRE, AREF x2 spaced 7, LMR addr=0x037, init_done=1 two cycles later.
REQ-025 Write len=4 addr {1,0x123,0x010} -> ACTIVE ba=1 addr=0x123, WRITE addr=0x010 2 cycles later, wr_data_en 4 cycles, BSTOP, PRECHARGE 2 later.
REQ-026 Read len=1 -> rd_data_valid single cycle at READ+3; BSTOP at READ+1; len=0 behaves identically.
REQ-027 Write len=256 col=0x1F0 -> wr_data_en 256 cycles, no second ACTIVE; refresh expiring mid-burst -> AREF after TRP, before next request.
REQ-028 req_valid held high as refresh expires in IDLE -> AREF first, req_ready=0 until T_RFC done; rst mid-read -> outputs at reset values next cycle, init restarts.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings, controller state encoding and mode-register fields.
package sdram_pkg;

    // {cke, cs_n, ras_n, cas_n, we_n}
    typedef logic [4:0] cmd_t;

    localparam cmd_t CMD_NOP       = 5'b10111;
    localparam cmd_t CMD_ACTIVE    = 5'b10011;
    localparam cmd_t CMD_READ      = 5'b10101;
    localparam cmd_t CMD_WRITE     = 5'b10100;
    localparam cmd_t CMD_BSTOP     = 5'b10110;
    localparam cmd_t CMD_PRECHARGE = 5'b10010;
    localparam cmd_t CMD_AREF      = 5'b10001;
    localparam cmd_t CMD_LMR       = 5'b10000;
    localparam cmd_t CMD_RESET     = 5'b01111;

    typedef enum logic [3:0] {
        ST_PWRUP,
        ST_INIT_PRE,
        ST_INIT_REF1,
        ST_INIT_REF2,
        ST_INIT_LMR,
        ST_IDLE,
        ST_REF,
        ST_ACT,
        ST_WR,
        ST_WBST,
        ST_RD,
        ST_RBST,
        ST_PRE
    } state_t;

    localparam logic [2:0] MR_BL_FULL_PAGE = 3'b111;
    localparam logic       MR_BT_SEQ       = 1'b0;
    localparam logic [1:0] MR_OP_STD       = 2'b00;
    localparam logic       MR_WB_BURST     = 1'b0;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // A9..A0 of the mode register for a given CAS latency
    function automatic logic [9:0] mode_word(input int unsigned cl);
        return {MR_WB_BURST, MR_OP_STD, 3'(cl), MR_BT_SEQ, MR_BL_FULL_PAGE};
    endfunction

endpackage

// File: rtl/sdram_ref_timer.sv
// Free-running refresh interval timer; raises a single sticky pending flag per interval.
module sdram_ref_timer
    import sdram_pkg::*;
#(
    parameter int unsigned REF_INTERVAL = 780
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic pending,
    output logic pending_nxt_c
);

    localparam int unsigned CW = max_u(1, $clog2(REF_INTERVAL));

    logic [CW-1:0] cnt_q, cnt_d;
    logic          pending_q;
    logic          due_c;

    assign due_c         = en && (cnt_q == CW'(REF_INTERVAL - 1));
    // a fresh expiry outranks a same-cycle clear so no interval is lost
    assign pending_nxt_c = due_c || (pending_q && !clr);
    assign pending       = pending_q;

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = due_c ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_nxt_c;
        end
    end

endmodule

// File: rtl/sdram_cmd_gen.sv
// SDRAM command generator: power-up init, auto refresh and single full-page read/write bursts.
module sdram_cmd_gen
    import sdram_pkg::*;
#(
    parameter int unsigned WIDTH_BA     = 2,
    parameter int unsigned WIDTH_ROW    = 13,
    parameter int unsigned WIDTH_COL    = 9,
    parameter int unsigned CL           = 3,
    parameter int unsigned T_RCD        = 2,
    parameter int unsigned T_RP         = 2,
    parameter int unsigned T_RFC        = 7,
    parameter int unsigned T_MRD        = 2,
    parameter int unsigned T_WR         = 2,
    parameter int unsigned T_PWRUP      = 20000,
    parameter int unsigned REF_INTERVAL = 780
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     req_valid,
    output logic                                     req_ready,
    input  logic                                     req_wr,
    input  logic [WIDTH_BA+WIDTH_ROW+WIDTH_COL-1:0]  req_addr,
    input  logic [8:0]                               req_len,
    output logic                                     init_done,
    output logic                                     wr_data_en,
    output logic                                     rd_data_valid,
    output logic                                     sdram_cke,
    output logic                                     sdram_cs_n,
    output logic                                     sdram_ras_n,
    output logic                                     sdram_cas_n,
    output logic                                     sdram_we_n,
    output logic [WIDTH_BA-1:0]                      sdram_ba,
    output logic [WIDTH_ROW-1:0]                     sdram_addr
);

    localparam int unsigned ADDR_W  = WIDTH_BA + WIDTH_ROW + WIDTH_COL;
    localparam int unsigned CNT_MAX = max_u(T_PWRUP, max_u(256, max_u(T_RFC, max_u(T_RP,
                                      max_u(T_RCD, max_u(T_MRD, max_u(T_WR, CL)))))));
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    cmd_t                 cmd_q, cmd_d;
    logic [WIDTH_BA-1:0]  ba_q, ba_d;
    logic [WIDTH_ROW-1:0] addr_q, addr_d;
    logic                 init_done_q, init_done_d;
    logic                 req_ready_q, req_ready_d;
    logic                 wr_en_q, wr_en_d;
    logic [CL-1:0]        rd_pipe_q, rd_pipe_d;

    logic                 wr_q;
    logic [WIDTH_BA-1:0]  bank_q;
    logic [WIDTH_COL-1:0] col_q;
    logic [7:0]           len_m1_q;

    logic                 hs_c;
    logic                 cnt_zero_c;
    logic                 ref_clr_c;
    logic                 ref_pending;
    logic                 ref_pending_nxt_c;

    logic [WIDTH_BA-1:0]  req_ba_c;
    logic [WIDTH_ROW-1:0] req_row_c;
    logic [WIDTH_COL-1:0] req_col_c;

    assign req_ba_c   = req_addr[ADDR_W-1 -: WIDTH_BA];
    assign req_row_c  = req_addr[WIDTH_COL +: WIDTH_ROW];
    assign req_col_c  = req_addr[WIDTH_COL-1:0];
    assign hs_c       = req_valid && req_ready_q;
    assign cnt_zero_c = (cnt_q == '0);

    sdram_ref_timer #(
        .REF_INTERVAL (REF_INTERVAL)
    ) u_ref_timer (
        .clk           (clk),
        .rst           (rst),
        .en            (init_done_q),
        .clr           (ref_clr_c),
        .pending       (ref_pending),
        .pending_nxt_c (ref_pending_nxt_c)
    );

    // Each state's command is issued on entry; cnt then counts down to the next command.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_zero_c ? '0 : cnt_q - CNT_W'(1);
        cmd_d     = CMD_NOP;
        ba_d      = '1;
        addr_d    = '1;
        ref_clr_c = 1'b0;

        case (state_q)
            ST_PWRUP: if (cnt_zero_c) begin
                state_d = ST_INIT_PRE;
                cmd_d   = CMD_PRECHARGE;
                cnt_d   = CNT_W'(T_RP - 1);
            end
            ST_INIT_PRE: if (cnt_zero_c) begin
                state_d = ST_INIT_REF1;
                cmd_d   = CMD_AREF;
                cnt_d   = CNT_W'(T_RFC - 1);
            end
            ST_INIT_REF1: if (cnt_zero_c) begin
                state_d = ST_INIT_REF2;
                cmd_d   = CMD_AREF;
                cnt_d   = CNT_W'(T_RFC - 1);
            end
            ST_INIT_REF2: if (cnt_zero_c) begin
                state_d = ST_INIT_LMR;
                cmd_d   = CMD_LMR;
                ba_d    = '0;
                addr_d  = WIDTH_ROW'(mode_word(CL));
                cnt_d   = CNT_W'(T_MRD - 1);
            end
            ST_INIT_LMR: if (cnt_zero_c) begin
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (ref_pending) begin
                    state_d = ST_REF;
                    cmd_d   = CMD_AREF;
                    cnt_d   = CNT_W'(T_RFC - 1);
                end else if (hs_c) begin
                    state_d = ST_ACT;
                    cmd_d   = CMD_ACTIVE;
                    ba_d    = req_ba_c;
                    addr_d  = req_row_c;
                    cnt_d   = CNT_W'(T_RCD - 1);
                end
            end
            ST_REF: if (cnt_zero_c) begin
                state_d   = ST_IDLE;
                ref_clr_c = 1'b1;
            end
            ST_ACT: if (cnt_zero_c) begin
                state_d = wr_q ? ST_WR : ST_RD;
                cmd_d   = wr_q ? CMD_WRITE : CMD_READ;
                ba_d    = bank_q;
                addr_d  = WIDTH_ROW'(col_q);
                cnt_d   = CNT_W'(len_m1_q);
            end
            ST_WR: if (cnt_zero_c) begin
                state_d = ST_WBST;
                cmd_d   = CMD_BSTOP;
                cnt_d   = CNT_W'(T_WR - 1);
            end
            ST_RD: if (cnt_zero_c) begin
                state_d = ST_RBST;
                cmd_d   = CMD_BSTOP;
                cnt_d   = CNT_W'(CL - 1);
            end
            ST_WBST, ST_RBST: if (cnt_zero_c) begin
                state_d = ST_PRE;
                cmd_d   = CMD_PRECHARGE;
                cnt_d   = CNT_W'(T_RP - 1);
            end
            ST_PRE: if (cnt_zero_c) begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_PWRUP;
                cnt_d   = CNT_W'(T_PWRUP);
            end
        endcase

        init_done_d = init_done_q || (state_d == ST_IDLE);
        // ready looks ahead so a refresh expiring next cycle already blocks the handshake
        req_ready_d = (state_d == ST_IDLE) && init_done_d && !ref_pending_nxt_c;
        wr_en_d     = (state_d == ST_WR);
        rd_pipe_d   = {rd_pipe_q[CL-2:0], (state_q == ST_RD)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_PWRUP;
            cnt_q       <= CNT_W'(T_PWRUP);
            cmd_q       <= CMD_RESET;
            ba_q        <= '1;
            addr_q      <= '1;
            init_done_q <= 1'b0;
            req_ready_q <= 1'b0;
            wr_en_q     <= 1'b0;
            rd_pipe_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            ba_q        <= ba_d;
            addr_q      <= addr_d;
            init_done_q <= init_done_d;
            req_ready_q <= req_ready_d;
            wr_en_q     <= wr_en_d;
            rd_pipe_q   <= rd_pipe_d;
        end
    end

    // Request capture; a zero length is run as a single word
    always_ff @(posedge clk) begin
        if (hs_c) begin
            wr_q     <= req_wr;
            bank_q   <= req_ba_c;
            col_q    <= req_col_c;
            len_m1_q <= (req_len == 9'd0) ? 8'd0 : 8'(req_len - 9'd1);
        end
    end

    assign {sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_q;
    assign sdram_ba      = ba_q;
    assign sdram_addr    = addr_q;
    assign init_done     = init_done_q;
    assign req_ready     = req_ready_q;
    assign wr_data_en    = wr_en_q;
    assign rd_data_valid = rd_pipe_q[CL-1];

endmodule

// File: tb/tb_sdram_cmd_gen.sv
// Scoreboard bench for sdram_cmd_gen: expected commands and data windows are queued at stimulus time.
module tb_sdram_cmd_gen;

    localparam int unsigned T_RCD   = 2;
    localparam int unsigned T_RP    = 2;
    localparam int unsigned T_RFC   = 7;
    localparam int unsigned T_WR    = 2;
    localparam int unsigned CL      = 3;
    localparam int unsigned REF_INT = 780;

    localparam logic [4:0] C_NOP  = 5'b10111;
    localparam logic [4:0] C_ACT  = 5'b10011;
    localparam logic [4:0] C_RD   = 5'b10101;
    localparam logic [4:0] C_WR   = 5'b10100;
    localparam logic [4:0] C_BST  = 5'b10110;
    localparam logic [4:0] C_PRE  = 5'b10010;
    localparam logic [4:0] C_AREF = 5'b10001;
    localparam logic [4:0] C_LMR  = 5'b10000;
    localparam logic [4:0] C_RST  = 5'b01111;

    typedef struct {
        logic [4:0]  cmd;
        logic [1:0]  ba;
        logic [12:0] addr;
        int unsigned cyc;
    } exp_t;

    typedef struct {
        int unsigned start;
        int unsigned len;
    } win_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_wr = 1'b0;
    logic [23:0] req_addr = '0;
    logic [8:0]  req_len = '0;
    logic        req_ready, init_done, wr_data_en, rd_data_valid;
    logic        sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_addr;

    int unsigned cyc = 0;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    exp_t exp_q[$];
    win_t wr_exp[$];
    win_t rd_exp[$];

    sdram_cmd_gen #(
        .T_PWRUP (10)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_wr        (req_wr),
        .req_addr      (req_addr),
        .req_len       (req_len),
        .init_done     (init_done),
        .wr_data_en    (wr_data_en),
        .rd_data_valid (rd_data_valid),
        .sdram_cke     (sdram_cke),
        .sdram_cs_n    (sdram_cs_n),
        .sdram_ras_n   (sdram_ras_n),
        .sdram_cas_n   (sdram_cas_n),
        .sdram_we_n    (sdram_we_n),
        .sdram_ba      (sdram_ba),
        .sdram_addr    (sdram_addr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_cmd(input logic [4:0] c, input logic [1:0] b, input logic [12:0] a,
                            input int unsigned t);
        exp_t e;
        e.cmd = c; e.ba = b; e.addr = a; e.cyc = t;
        exp_q.push_back(e);
    endtask

    task automatic push_win(input bit is_wr, input int unsigned s, input int unsigned l);
        win_t w;
        w.start = s; w.len = l;
        if (is_wr) wr_exp.push_back(w);
        else       rd_exp.push_back(w);
    endtask

    // k: first cycle after release whose outputs leave reset
    task automatic push_init(input int unsigned k);
        push_cmd(C_PRE,  2'b11, 13'h1FFF, k + 10);
        push_cmd(C_AREF, 2'b11, 13'h1FFF, k + 12);
        push_cmd(C_AREF, 2'b11, 13'h1FFF, k + 19);
        push_cmd(C_LMR,  2'b00, 13'h0037, k + 26);
    endtask

    task automatic check_reset_outputs();
        chk("rst_cmd", 32'({sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}), 32'(C_RST));
        chk("rst_ba", 32'(sdram_ba), 32'h3);
        chk("rst_addr", 32'(sdram_addr), 32'h1FFF);
        chk("rst_init_done", 32'(init_done), 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_wr_data_en", 32'(wr_data_en), 32'h0);
        chk("rst_rd_data_valid", 32'(rd_data_valid), 32'h0);
    endtask

    // Called at a negedge; returns at the negedge after the handshake.
    task automatic do_req(input bit wr, input logic [1:0] ba, input logic [12:0] row,
                          input logic [8:0] col, input logic [8:0] len,
                          output int unsigned acc, output int unsigned idle);
        int unsigned n = 0;
        int unsigned ln, c, bst, pre;
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = {ba, row, col};
        req_len   = len;
        acc  = 0;
        idle = 0;
        while (!req_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("req_accept_timeout", 32'(n), 32'(0));
            req_valid = 1'b0;
        end else begin
            acc = cyc;
            ln  = (len == 9'd0) ? 1 : 32'(len);
            c   = acc + 1 + T_RCD;
            bst = c + ln;
            pre = wr ? bst + T_WR : bst + CL;
            push_cmd(C_ACT, ba, row, acc + 1);
            push_cmd(wr ? C_WR : C_RD, ba, 13'(col), c);
            push_win(wr, wr ? c : c + CL, ln);
            push_cmd(C_BST, 2'b11, 13'h1FFF, bst);
            push_cmd(C_PRE, 2'b11, 13'h1FFF, pre);
            idle = pre + T_RP;
            @(posedge clk);
            #1 req_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        while (!(exp_q.size() == 0 && wr_exp.size() == 0 && rd_exp.size() == 0 && req_ready)
               && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(n < 3000), 32'(1));
    endtask

    // Command and data-strobe monitor
    bit          wr_run = 1'b0, rd_run = 1'b0;
    int unsigned wr_start, wr_len, rd_start, rd_len;

    always @(negedge clk) begin : monitor
        logic [4:0] c;
        exp_t       e;
        win_t       w;
        c = {sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
        if (c[4] && c != C_NOP) begin
            if (exp_q.size() == 0) begin
                chk("cmd_unexpected", 32'(c), 32'(C_NOP));
            end else begin
                e = exp_q.pop_front();
                chk("cmd_code", 32'(c), 32'(e.cmd));
                chk("cmd_ba", 32'(sdram_ba), 32'(e.ba));
                chk("cmd_addr", 32'(sdram_addr), 32'(e.addr));
                chk("cmd_cycle", cyc, e.cyc);
            end
        end
        if (wr_data_en) begin
            if (!wr_run) begin wr_run = 1'b1; wr_start = cyc; wr_len = 0; end
            wr_len++;
        end else if (wr_run) begin
            wr_run = 1'b0;
            if (wr_exp.size() == 0) chk("wr_en_unexpected", wr_len, 0);
            else begin
                w = wr_exp.pop_front();
                chk("wr_en_start", wr_start, w.start);
                chk("wr_en_len", wr_len, w.len);
            end
        end
        if (rd_data_valid) begin
            if (!rd_run) begin rd_run = 1'b1; rd_start = cyc; rd_len = 0; end
            rd_len++;
        end else if (rd_run) begin
            rd_run = 1'b0;
            if (rd_exp.size() == 0) chk("rd_valid_unexpected", rd_len, 0);
            else begin
                w = rd_exp.pop_front();
                chk("rd_valid_start", rd_start, w.start);
                chk("rd_valid_len", rd_len, w.len);
            end
        end
    end

    initial begin : main
        int unsigned k, idone, acc, idle, idle5, p;

        repeat (3) @(negedge clk);
        check_reset_outputs();
        k = cyc + 1;
        push_init(k);
        rst = 1'b0;
        while (cyc < k + 27) @(negedge clk);
        chk("init_done_early", 32'(init_done), 32'(0));
        @(negedge clk);
        chk("init_done", 32'(init_done), 32'(1));
        idone = k + 28;

        do_req(1'b1, 2'd1, 13'h123, 9'h010, 9'd4, acc, idle);
        wait_idle();
        do_req(1'b0, 2'd2, 13'h0AB, 9'h005, 9'd1, acc, idle);
        wait_idle();
        do_req(1'b0, 2'd3, 13'h1FFF, 9'h1FF, 9'd0, acc, idle);
        wait_idle();
        do_req(1'b0, 2'd0, 13'h0007, 9'h1FC, 9'd8, acc, idle);
        wait_idle();

        // long write with the first refresh expiring in the middle of the burst
        while (cyc < idone + 680) @(negedge clk);
        do_req(1'b1, 2'd0, 13'h0042, 9'h1F0, 9'd256, acc, idle5);
        push_cmd(C_AREF, 2'b11, 13'h1FFF, idle5 + 1);
        do_req(1'b0, 2'd3, 13'h1000, 9'h0FF, 9'd2, acc, idle);
        chk("req_after_refresh", acc, idle5 + 1 + T_RFC);
        wait_idle();

        // request raised exactly as the second refresh expires in IDLE
        p = idone + 2 * REF_INT;
        while (cyc < p) @(negedge clk);
        push_cmd(C_AREF, 2'b11, 13'h1FFF, p + 1);
        chk("ready_at_expiry", 32'(req_ready), 32'(0));
        do_req(1'b1, 2'd2, 13'h1FFF, 9'h000, 9'd3, acc, idle);
        chk("req_after_expiry", acc, p + 1 + T_RFC);
        wait_idle();

        // reset in the middle of a read burst
        do_req(1'b0, 2'd1, 13'h0777, 9'h100, 9'd64, acc, idle);
        while (cyc < acc + 1 + T_RCD + 2) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        wr_exp.delete();
        rd_exp.delete();
        @(negedge clk);
        check_reset_outputs();
        @(negedge clk);
        k = cyc + 1;
        push_init(k);
        rst = 1'b0;
        while (cyc < k + 27) @(negedge clk);
        chk("reinit_done_early", 32'(init_done), 32'(0));
        @(negedge clk);
        chk("reinit_done", 32'(init_done), 32'(1));

        do_req(1'b1, 2'd3, 13'h0ABC, 9'h1FF, 9'd2, acc, idle);
        wait_idle();
        chk("init_done_sticky", 32'(init_done), 32'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
